tc_timer: RTL and testbench
===========================

// Module: tc_timer
// PURPOSE
//   Memory-mapped countdown timer on the CPU data bus, downstream of the mips core.
//   Consumes the core's M-stage data port (m_data_addr/m_data_wdata/m_data_byteen)
//   and returns combinational read data for the M-stage load path.
//   Raises an interrupt request when the count expires.
//   Single clock domain.
// PARAMETERS
//   BASE_ADDR  32'h0000_7F00  word-aligned base; decodes a 16-byte window [BASE, BASE+0xF]
// PORTS
//   clk      in   1   system clock; all state updates on posedge clk
//   reset    in   1   synchronous reset, active-high
//   addr     in   32  data address (m_data_addr)
//   wdata    in   32  store data (m_data_wdata)
//   byteen   in   4   store byte enables (m_data_byteen)
//   hit      out  1   addr[31:4] == BASE_ADDR[31:4], combinational
//   rdata    out  32  read data for addr, combinational
//   irq      out  1   interrupt request, registered
// BEHAVIOUR
//   Register map (offset = addr[3:2]):
//     0 CTRL    R/W   [0]=EN, [2:1]=MODE, [3]=IM; bits [31:4] read 0
//     1 PRESET  R/W   reload value
//     2 COUNT   R     current count; writes ignored
//     3         -     reads 0; writes ignored
//   Write strobe: we = hit & (byteen == 4'b1111). Partial-byte stores are ignored entirely.
//   rdata is 0 when hit == 0.
//   Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, pending=0, irq=0.
//   FSM states, one transition per clock:
//     IDLE  EN=1 -> LOAD; else stay.
//     LOAD  COUNT <= PRESET -> CNT.
//     CNT   EN=0        -> IDLE; COUNT holds.
//           COUNT > 1   -> COUNT <= COUNT-1, stay in CNT.
//           COUNT <= 1  -> COUNT <= 0, go to INT.
//     INT   MODE=00 -> EN <= 0, go to IDLE (one-shot).
//           MODE=01 -> go to IDLE with EN kept (auto-reload).
//           MODE=1x -> treated as 00.
//   pending:
//     - Set on the edge entering INT when MODE=00.
//     - Cleared by any CPU write to CTRL or PRESET.
//   irq:
//     - MODE=00: irq = IM & pending (level).
//     - MODE=01: irq = IM & (state==INT) (one-cycle pulse).
//     - irq is driven from registers only; no combinational path from bus inputs.
//   Latency (CTRL write with EN=1 lands on edge E0, PRESET=N>=1):
//     - LOAD after E1.
//     - COUNT=N after E2.
//     - COUNT=0 and INT after E(2+N).
//     - MODE=01 period: N+3 cycles between INT cycles.
//   PRESET=0: LOAD sets COUNT=0; CNT enters INT on the next edge.
//   Boundary and simultaneity rules:
//     - Simultaneous CPU write to CTRL and FSM clearing EN in INT: CPU write wins.
//     - PRESET write mid-count affects only the next LOAD; current COUNT is unchanged.
//     - CTRL write with EN=0 during CNT: COUNT freezes, FSM goes to IDLE next edge.
//       Re-enabling reloads from PRESET; there is no resume.
//     - COUNT never underflows; 32-bit unsigned, no wrap.
//     - reset asserted mid-count: all state returns to reset values on that edge;
//       irq drops the same edge.
// TESTING
//   1. Reset, then read offsets 0/1/2 at BASE -> rdata=0, irq=0, hit=1.
//      addr=BASE+0x10 -> hit=0, rdata=0.
//   2. PRESET=5, then CTRL=0x9 (EN, MODE0, IM) at edge E0 -> COUNT reads 5,4,3,2,1,0
//      after E2..E7; irq rises after E7 and stays high; EN reads 0 after E8.
//      Writing CTRL=0 then drops irq.
//   3. PRESET=3, CTRL=0xB (MODE1, IM) -> one-cycle irq pulses every 6 cycles;
//      EN stays 1; COUNT reloads to 3.
//   4. Mid-count (COUNT=3, PRESET=10): write PRESET=2 -> COUNT continues 2,1,0.
//      Write CTRL with EN=0 at COUNT=7 -> COUNT holds 7, state IDLE.
//   5. Store to PRESET with byteen=4'b0011 -> PRESET unchanged.
//      Store to COUNT with byteen=4'hF -> COUNT unchanged.
//   6. PRESET=0, MODE0, IM=1 -> INT after E3, irq high.
//      Assert reset while irq is high -> irq=0 and all registers 0 on the next edge.

Source files
------------

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped countdown timer on the CPU data bus.
// A 16-byte register window holds CTRL, PRESET and COUNT. A small FSM
// reloads COUNT from PRESET, counts down to zero and raises an interrupt.
// It supports one-shot mode (level irq held by a pending flag) and
// auto-reload mode (a one-cycle irq pulse per period).
//
//   state | meaning
//   IDLE  | waiting for EN
//   LOAD  | copy PRESET into COUNT
//   CNT   | decrement COUNT until it expires
//   INT   | count expired; one-shot clears EN, auto-reload keeps it
module tc_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        en, im;
  logic [1:0]  mode;
  logic [31:0] preset, count, count_nxt;
  logic        pending;
  logic        en_clr, pend_set;
  logic        we, we_ctrl, we_preset;
  logic        auto_reload;
  logic        unused_addr_bits;

  // The window is word-addressed; the byte offset bits do not matter.
  assign unused_addr_bits = ^addr[1:0];

  // Address decode and full-word write strobes.
  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign we          = hit & (byteen == 4'b1111);
  assign we_ctrl     = we & (addr[3:2] == 2'd0);
  assign we_preset   = we & (addr[3:2] == 2'd1);
  assign auto_reload = (mode == 2'b01);

  // Combinational read mux; zero outside the window and at the reserved slot.
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (addr[3:2])
        2'd0:    rdata = {28'd0, im, mode, en};
        2'd1:    rdata = preset;
        2'd2:    rdata = count;
        default: rdata = 32'd0;
      endcase
    end
  end

  // Next-state and count update; one transition per clock.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    en_clr    = 1'b0;
    pend_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          count_nxt = 32'd0;
          state_nxt = ST_INT;
          pend_set  = ~auto_reload;
        end
      end
      ST_INT: begin
        state_nxt = ST_IDLE;
        en_clr    = ~auto_reload;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, count and register-file updates; CPU writes take priority over the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= 32'd0;
      en      <= 1'b0;
      mode    <= 2'b00;
      im      <= 1'b0;
      preset  <= 32'd0;
      pending <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (we_ctrl) begin
        en   <= wdata[0];
        mode <= wdata[2:1];
        im   <= wdata[3];
      end else if (en_clr) begin
        en <= 1'b0;
      end
      if (we_preset) preset <= wdata;
      if (we_ctrl | we_preset) pending <= 1'b0;
      else if (pend_set)       pending <= 1'b1;
    end
  end

  // irq depends only on flops, so there is no combinational path from the bus.
  always_comb begin
    irq = im & (auto_reload ? (state == ST_INT) : pending);
  end

endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: directed scenarios plus random bus traffic, every cycle
// compared against a behavioural model of the timer's register-level rules.
module tb_tc_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam int P_IDLE = 0, P_LOAD = 1, P_CNT = 2, P_INT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic [3:0]  byteen;
  logic        hit, irq;
  logic [31:0] rdata;

  int n_chk = 0;
  int n_err = 0;

  // model state
  int          m_phase;
  bit          m_en, m_im, m_pend;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;

  tc_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .byteen(byteen), .hit(hit), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_irq();
    if (m_mode == 2'b01) return m_im && (m_phase == P_INT);
    return m_im && m_pend;
  endfunction

  // Apply one clock edge of the timer's rules to the model.
  task automatic model_step(input bit r, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    bit          wr, wc, wp;
    int          n_phase;
    bit          n_en, n_pend;
    logic [31:0] n_count;
    wr = (a[31:4] == BASE[31:4]) && (be == 4'hF);
    wc = wr && (a[3:2] == 2'd0);
    wp = wr && (a[3:2] == 2'd1);
    if (r) begin
      m_phase = P_IDLE; m_en = 0; m_im = 0; m_pend = 0;
      m_mode = 0; m_preset = 0; m_count = 0;
      return;
    end
    n_phase = m_phase; n_en = m_en; n_pend = m_pend; n_count = m_count;
    case (m_phase)
      P_IDLE: if (m_en) n_phase = P_LOAD;
      P_LOAD: begin n_count = m_preset; n_phase = P_CNT; end
      P_CNT: begin
        if (!m_en) n_phase = P_IDLE;
        else if (m_count > 1) n_count = m_count - 1;
        else begin
          n_count = 0; n_phase = P_INT;
          if (m_mode != 2'b01) n_pend = 1;
        end
      end
      default: begin
        n_phase = P_IDLE;
        if (m_mode != 2'b01) n_en = 0;
      end
    endcase
    if (wc) begin n_en = d[0]; m_mode = d[2:1]; m_im = d[3]; n_pend = 0; end
    if (wp) begin m_preset = d; n_pend = 0; end
    m_phase = n_phase; m_en = n_en; m_pend = n_pend; m_count = n_count;
  endtask

  // Drive one bus cycle, clock it, then read back and compare everything.
  task automatic tick(input bit r, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    reset = r; addr = a; wdata = d; byteen = be;
    @(posedge clk);
    model_step(r, a, d, be);
    #1;
    reset = 0; wdata = 0; byteen = 0; addr = 0;
    chk("irq", {31'd0, irq}, {31'd0, m_irq()});
    addr = BASE;       #1 chk("ctrl", rdata, {28'd0, m_im, m_mode, m_en});
    addr = BASE + 4;   #1 chk("preset", rdata, m_preset);
    addr = BASE + 8;   #1 chk("count", rdata, m_count);
    addr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 32'd0, 32'd0, 4'h0);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    tick(0, BASE + {28'd0, off}, d, 4'hF);
  endtask

  initial begin
    int pulses, iters;
    reset = 1; addr = 0; wdata = 0; byteen = 0;
    m_phase = P_IDLE; m_en = 0; m_im = 0; m_pend = 0;
    m_mode = 0; m_preset = 0; m_count = 0;
    tick(1, 32'd0, 32'd0, 4'h0);

    // 1: reset values and decode
    for (int o = 0; o < 4; o++) begin
      addr = BASE + o * 4; #1;
      chk("rst_rd", rdata, 32'd0);
      chk("rst_hit", {31'd0, hit}, 32'd1);
    end
    chk("rst_irq", {31'd0, irq}, 32'd0);
    addr = BASE + 32'h10; #1;
    chk("nohit", {31'd0, hit}, 32'd0);
    chk("nohit_rd", rdata, 32'd0);
    addr = BASE - 4; #1;
    chk("nohit_lo", {31'd0, hit}, 32'd0);

    // 2: one-shot, PRESET=5
    wr(4, 5);
    wr(0, 32'h9);            // E0
    idle(1);                 // E1 -> LOAD
    for (int k = 5; k >= 0; k--) begin
      idle(1);               // E2..E7
      chk("os_count", m_count, k);
      addr = BASE + 8; #1 chk("os_count_dut", rdata, k); addr = 0;
    end
    chk("os_irq", {31'd0, irq}, 32'd1);
    idle(1);                 // E8
    addr = BASE; #1 chk("os_en_clr", rdata, 32'h8); addr = 0;
    idle(3);
    chk("os_irq_held", {31'd0, irq}, 32'd1);
    wr(0, 32'h0);
    chk("os_irq_drop", {31'd0, irq}, 32'd0);

    // 3: auto-reload, PRESET=3, period 6
    wr(4, 3);
    wr(0, 32'hB);
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      idle(1);
      if (irq) pulses++;
    end
    chk("ar_pulses", pulses, 4);
    addr = BASE; #1 chk("ar_en", rdata, 32'hB); addr = 0;
    wr(0, 32'h0);

    // 4a: PRESET rewrite mid-count does not disturb COUNT
    wr(4, 10);
    wr(0, 32'h9);
    iters = 0;
    while (m_count != 3 && iters < 40) begin idle(1); iters++; end
    chk("mid_reach3", m_count, 3);
    wr(4, 2);
    idle(3);
    chk("mid_zero", m_count, 0);
    idle(2);
    wr(0, 32'h0);
    // 4b: disable at COUNT=7 freezes, re-enable reloads
    wr(4, 10);
    wr(0, 32'h1);
    iters = 0;
    while (m_count != 8 && iters < 40) begin idle(1); iters++; end
    wr(0, 32'h0);            // FSM still counts this edge, lands on 7
    idle(4);
    addr = BASE + 8; #1 chk("frz_count", rdata, 32'd7); addr = 0;
    wr(0, 32'h1);
    idle(2);
    chk("reload", m_count, 10);

    // 5: partial stores and COUNT writes ignored
    tick(0, BASE + 4, 32'h55, 4'b0011);
    tick(0, BASE + 8, 32'h1234, 4'hF);
    tick(0, BASE + 12, 32'hFFFF_FFFF, 4'hF);
    wr(0, 32'h0);

    // 6: PRESET=0 one-shot, then reset while irq high
    wr(4, 0);
    wr(0, 32'h9);            // E0
    idle(3);                 // E3 -> INT
    chk("p0_irq", {31'd0, irq}, 32'd1);
    tick(1, 32'd0, 32'd0, 4'h0);
    chk("rst_irq2", {31'd0, irq}, 32'd0);
    addr = BASE; #1 chk("rst_ctrl2", rdata, 32'd0); addr = 0;

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 1) tick(1, 32'd0, 32'd0, 4'h0);
      else if (sel < 80) idle(1);
      else begin
        logic [1:0]  off;
        logic [3:0]  be;
        logic [31:0] d;
        off = 2'($urandom_range(0, 3));
        be  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        d   = (off == 2'd0) ? 32'($urandom_range(0, 15)) | ($urandom() & 32'hFFFF_FFF0)
                            : 32'($urandom_range(0, 7));
        tick(0, BASE + {28'd0, off, 2'b00}, d, be);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
